// File: rtl/note_match_judge_pkg.sv
// ----------------------------------------------------------------------------
// judge_pkg
// Shared definitions for the note match judge:
//   - state_t        : judge FSM encoding (IDLE=0, ARMED=1)
//   - DEFAULT_*      : default values for the WIDTH, WINDOW and SCORE_W parameters
//   - CNT_W          : width of the window counter (holds WINDOW-1 for WINDOW<=255)
//   - combo_inc()    : saturating increment for the 8-bit combo counter
// ----------------------------------------------------------------------------
package judge_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_WINDOW  = 8;
    localparam int DEFAULT_SCORE_W = 16;

    localparam int CNT_W = 8;

    // The combo count sticks at 255 instead of wrapping back to zero.
    function automatic logic [7:0] combo_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/note_match_judge_compare.sv
// ----------------------------------------------------------------------------
// compare_nbit
// Exact lane-by-lane equality of two key vectors. Every lane must agree, so a
// missing key or an extra key both count as a mismatch.
// Ports:
//   A, B   in  [WIDTH-1:0]  vectors to compare
//   equal  out              1 when A and B match on every lane
// ----------------------------------------------------------------------------
module compare_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             equal
);

    // XNOR per lane gives 1 where the lanes agree; AND-reduce demands all agree.
    assign equal = &(A ~^ B);

endmodule

// File: rtl/note_match_judge.sv
// ----------------------------------------------------------------------------
// note_match_judge
// Judges whether the player presses exactly the expected key pattern within a
// window of WINDOW clock cycles after each note strobe, and keeps a saturating
// score and a saturating combo (consecutive hit) count.
//
// Optional feature macro: NOTE_MATCH_JUDGE_PERFECT_EN
//   When defined, adds the 'perfect' output, which pulses with 'hit' when the
//   match lands in the first ceil(WINDOW/2) compare cycles; such a hit adds 2
//   to the score instead of 1.
//
// Ports:
//   clk           in              system clock, rising edge
//   rst_n         in              asynchronous active-low reset
//   note_valid    in              one-cycle strobe for a new expected note
//   note_pattern  in  [WIDTH-1:0] expected key vector (all-zero is ignored)
//   keys          in  [WIDTH-1:0] synchronised, debounced key vector
//   armed         out             high while a note is being judged
//   hit           out             one-cycle pulse: note matched in window
//   miss          out             one-cycle pulse: note not matched
//   score         out [SCORE_W-1:0] accumulated score (saturating)
//   combo         out [7:0]       consecutive hit count (saturating)
//   perfect       out             (macro only) early-hit pulse
// ----------------------------------------------------------------------------
module note_match_judge
    import judge_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int WINDOW  = DEFAULT_WINDOW,
    parameter int SCORE_W = DEFAULT_SCORE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               note_valid,
    input  logic [WIDTH-1:0]   note_pattern,
    input  logic [WIDTH-1:0]   keys,
    output logic               armed,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    ,
    output logic               perfect
`endif
);

    // The counter is loaded with WINDOW-1 and a miss is declared on the compare
    // cycle where it reads zero, which gives exactly WINDOW compare cycles.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WINDOW - 1);

`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    // Compare cycle k (1-based) sees cnt == WINDOW-k, so k <= ceil(WINDOW/2)
    // is the same as cnt >= floor(WINDOW/2).
    localparam logic [CNT_W-1:0] PERFECT_MIN = CNT_W'(WINDOW / 2);
`endif

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   pat, pat_next;
    logic               hit_next, miss_next;
    logic [SCORE_W-1:0] score_next;
    logic [7:0]         combo_next;
    logic               match;
    logic               new_note;
    logic [SCORE_W:0]   score_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    logic               early;
    logic               perfect_next;
`endif

    compare_nbit #(
        .WIDTH (WIDTH)
    ) u_compare (
        .A     (keys),
        .B     (pat),
        .equal (match)
    );

    // A strobe carrying an empty pattern is not a note at all.
    assign new_note = note_valid && (note_pattern != '0);
    assign armed    = (state == ARMED);

    // Score increment and saturating sum; the extra top bit of the sum flags
    // an overflow, in which case the score is pinned at all-ones.
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    assign early     = (cnt >= PERFECT_MIN);
    assign score_inc = early ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);
`else
    assign score_inc = (SCORE_W+1)'(1);
`endif
    assign score_sum = {1'b0, score} + score_inc;
    assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Next-state and next-output logic. In ARMED a match wins over everything,
    // so a new note arriving on the matching cycle still credits the old note
    // with a hit; the new note then restarts the window without leaving ARMED.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pat_next     = pat;
        hit_next     = 1'b0;
        miss_next    = 1'b0;
        score_next   = score;
        combo_next   = combo;
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
        perfect_next = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (new_note) begin
                    pat_next   = note_pattern;
                    cnt_next   = RELOAD;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (match) begin
                    hit_next   = 1'b1;
                    score_next = score_sat;
                    combo_next = combo_inc(combo);
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
                    perfect_next = early;
`endif
                    if (new_note) begin
                        pat_next = note_pattern;
                        cnt_next = RELOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (new_note) begin
                    miss_next  = 1'b1;
                    combo_next = 8'd0;
                    pat_next   = note_pattern;
                    cnt_next   = RELOAD;
                end else if (cnt == '0) begin
                    miss_next  = 1'b1;
                    combo_next = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any note in flight without
    // producing a hit or miss pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pat     <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
            combo   <= 8'd0;
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
            perfect <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pat     <= pat_next;
            hit     <= hit_next;
            miss    <= miss_next;
            score   <= score_next;
            combo   <= combo_next;
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
            perfect <= perfect_next;
`endif
        end
    end

endmodule

// File: tb/tb_note_match_judge.sv
// ----------------------------------------------------------------------------
// tb_note_match_judge
// Directed self-checking bench for note_match_judge with WIDTH=4, WINDOW=8.
// SCORE_W is set to 8 so score saturation can be reached in a short run.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_match_judge;

    localparam int WIDTH   = 4;
    localparam int WINDOW  = 8;
    localparam int SCORE_W = 8;

    logic               clk;
    logic               rst_n;
    logic               note_valid;
    logic [WIDTH-1:0]   note_pattern;
    logic [WIDTH-1:0]   keys;
    logic               armed;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [7:0]         combo;
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    logic               perfect;
`endif

    int checks = 0;
    int errors = 0;
    int exp_score = 0;
    int exp_combo = 0;

    note_match_judge #(
        .WIDTH   (WIDTH),
        .WINDOW  (WINDOW),
        .SCORE_W (SCORE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .note_valid   (note_valid),
        .note_pattern (note_pattern),
        .keys         (keys),
        .armed        (armed),
        .hit          (hit),
        .miss         (miss),
        .score        (score),
        .combo        (combo)
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
        ,
        .perfect      (perfect)
`endif
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic nv, input logic [WIDTH-1:0] pat,
                                 input logic [WIDTH-1:0] k);
        note_valid   = nv;
        note_pattern = pat;
        keys         = k;
    endtask

    // Strobe a note for one cycle; on return the block should be ARMED and the
    // next tick evaluates compare cycle 1.
    task automatic send_note(input logic [WIDTH-1:0] pat, input logic [WIDTH-1:0] k);
        applyStimulus(1'b1, pat, k);
        tick();
        applyStimulus(1'b0, 4'b0000, k);
    endtask

    // Expected score gain for a hit on compare cycle k (1-based)
    function automatic int hit_gain(input int k);
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
        return (k <= (WINDOW + 1) / 2) ? 2 : 1;
`else
        return 1;
`endif
    endfunction

    function automatic void model_hit(input int k);
        exp_score = exp_score + hit_gain(k);
        if (exp_score > 255) exp_score = 255;
        exp_combo = (exp_combo >= 255) ? 255 : exp_combo + 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        tick();
        tick();
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed: got %0b want 0", armed); end
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %0b want 0", hit); end
        checks++; if (miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_miss: got %0b want 0", miss); end
        checks++; if (score !== 8'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        checks++; if (combo !== 8'd0) begin errors++; $display("[TB] FAIL reset_combo: got %0d want 0", combo); end
        rst_n = 1'b1;
        tick();
        exp_score = 0;
        exp_combo = 0;
    endtask

    // Pattern 0101, match on the third compare cycle
    task automatic test_hit();
        send_note(4'b0101, 4'b0000);
        checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL hit_armed: got %0b want 1", armed); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (hit !== 1'b0 || miss !== 1'b0) begin errors++; $display("[TB] FAIL hit_early_idle: hit=%0b miss=%0b want 0/0", hit, miss); end
        end
        keys = 4'b0101;
        tick();
        model_hit(3);
        checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("[TB] FAIL hit_pulse: hit=%0b miss=%0b want 1/0", hit, miss); end
        checks++; if (score !== SCORE_W'(exp_score)) begin errors++; $display("[TB] FAIL hit_score: got %0d want %0d", score, exp_score); end
        checks++; if (combo !== 8'd1) begin errors++; $display("[TB] FAIL hit_combo: got %0d want 1", combo); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL hit_armed_fall: got %0b want 0", armed); end
        keys = 4'b0000;
        tick();
        checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL hit_one_cycle: got %0b want 0", hit); end
    endtask

    // Pattern 0011 against an extra key (0111) for the full window
    task automatic test_miss();
        send_note(4'b0011, 4'b0111);
        for (int i = 1; i <= WINDOW - 1; i++) begin
            tick();
            checks++; if (miss !== 1'b0 || armed !== 1'b1) begin errors++; $display("[TB] FAIL miss_window_c%0d: miss=%0b armed=%0b want 0/1", i, miss, armed); end
        end
        tick();
        checks++; if (miss !== 1'b1 || hit !== 1'b0) begin errors++; $display("[TB] FAIL miss_pulse: miss=%0b hit=%0b want 1/0", miss, hit); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL miss_armed: got %0b want 0", armed); end
        checks++; if (combo !== 8'd0) begin errors++; $display("[TB] FAIL miss_combo: got %0d want 0", combo); end
        checks++; if (score !== SCORE_W'(exp_score)) begin errors++; $display("[TB] FAIL miss_score: got %0d want %0d", score, exp_score); end
        exp_combo = 0;
        keys = 4'b0000;
        tick();
        checks++; if (miss !== 1'b0) begin errors++; $display("[TB] FAIL miss_one_cycle: got %0b want 0", miss); end
    endtask

    // New note while ARMED without a match: miss for the old note, stay armed
    task automatic test_rearm();
        send_note(4'b0110, 4'b0000);
        tick();
        applyStimulus(1'b1, 4'b1000, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checks++; if (miss !== 1'b1 || hit !== 1'b0) begin errors++; $display("[TB] FAIL rearm_miss: miss=%0b hit=%0b want 1/0", miss, hit); end
        checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL rearm_armed: got %0b want 1", armed); end
        exp_combo = 0;
        tick();
        checks++; if (miss !== 1'b0 || hit !== 1'b0) begin errors++; $display("[TB] FAIL rearm_quiet: miss=%0b hit=%0b want 0/0", miss, hit); end
        keys = 4'b1000;
        tick();
        model_hit(2);
        checks++; if (hit !== 1'b1 || armed !== 1'b0) begin errors++; $display("[TB] FAIL rearm_hit: hit=%0b armed=%0b want 1/0", hit, armed); end
        checks++; if (score !== SCORE_W'(exp_score)) begin errors++; $display("[TB] FAIL rearm_score: got %0d want %0d", score, exp_score); end
        keys = 4'b0000;
        tick();
    endtask

    // Match and new note on the same cycle: hit wins, new note stays armed
    task automatic test_back_to_back();
        send_note(4'b0001, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 4'b0001);
        tick();
        model_hit(1);
        checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_hit: hit=%0b miss=%0b want 1/0", hit, miss); end
        checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL b2b_armed: got %0b want 1", armed); end
        applyStimulus(1'b0, 4'b0000, 4'b0010);
        tick();
        model_hit(1);
        checks++; if (hit !== 1'b1 || armed !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_hit: hit=%0b armed=%0b want 1/0", hit, armed); end
        checks++; if (combo !== 8'(exp_combo)) begin errors++; $display("[TB] FAIL b2b_combo: got %0d want %0d", combo, exp_combo); end
        checks++; if (score !== SCORE_W'(exp_score)) begin errors++; $display("[TB] FAIL b2b_score: got %0d want %0d", score, exp_score); end
        keys = 4'b0000;
        tick();
    endtask

    // Reset mid-window, then an all-zero note is ignored
    task automatic test_reset_midwindow();
        send_note(4'b0100, 4'b0000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (armed !== 1'b0 || score !== 8'd0 || combo !== 8'd0 || hit !== 1'b0 || miss !== 1'b0)
            begin errors++; $display("[TB] FAIL async_reset: armed=%0b score=%0d combo=%0d hit=%0b miss=%0b want all 0", armed, score, combo, hit, miss); end
        tick();
        #2;
        rst_n = 1'b1;
        exp_score = 0;
        exp_combo = 0;
        keys = 4'b0100;
        for (int i = 0; i < WINDOW + 2; i++) begin
            tick();
            checks++; if (hit !== 1'b0 || miss !== 1'b0 || armed !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_quiet: hit=%0b miss=%0b armed=%0b want 0/0/0", hit, miss, armed); end
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL zero_note_armed: got %0b want 0", armed); end
        tick();
        checks++; if (armed !== 1'b0 || miss !== 1'b0) begin errors++; $display("[TB] FAIL zero_note_idle: armed=%0b miss=%0b want 0/0", armed, miss); end
    endtask

    // 257 consecutive hits: score and combo both pin at 255
    task automatic test_saturation();
        logic [WIDTH-1:0] p;
        for (int i = 0; i < 257; i++) begin
            p = WIDTH'((i % 15) + 1);
            send_note(p, 4'b0000);
            keys = p;
            tick();
            model_hit(1);
            checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL sat_hit_%0d: got %0b want 1", i, hit); end
            if (i >= 250) begin
                checks++; if (score !== SCORE_W'(exp_score)) begin errors++; $display("[TB] FAIL sat_score_%0d: got %0d want %0d", i, score, exp_score); end
                checks++; if (combo !== 8'(exp_combo)) begin errors++; $display("[TB] FAIL sat_combo_%0d: got %0d want %0d", i, combo, exp_combo); end
            end
            keys = 4'b0000;
        end
        checks++; if (score !== 8'hFF) begin errors++; $display("[TB] FAIL sat_score_final: got %0d want 255", score); end
        checks++; if (combo !== 8'hFF) begin errors++; $display("[TB] FAIL sat_combo_final: got %0d want 255", combo); end
        tick();
    endtask

`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
    // Early match (cycle 2) is perfect and worth 2; late match (cycle 6) is worth 1
    task automatic test_perfect();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_note(4'b1010, 4'b0000);
        tick();
        keys = 4'b1010;
        tick();
        checks++; if (hit !== 1'b1 || perfect !== 1'b1) begin errors++; $display("[TB] FAIL perfect_early: hit=%0b perfect=%0b want 1/1", hit, perfect); end
        checks++; if (score !== 8'd2) begin errors++; $display("[TB] FAIL perfect_early_score: got %0d want 2", score); end
        send_note(4'b1010, 4'b0000);
        for (int i = 1; i <= 5; i++) tick();
        keys = 4'b1010;
        tick();
        checks++; if (hit !== 1'b1 || perfect !== 1'b0) begin errors++; $display("[TB] FAIL perfect_late: hit=%0b perfect=%0b want 1/0", hit, perfect); end
        checks++; if (score !== 8'd3) begin errors++; $display("[TB] FAIL perfect_late_score: got %0d want 3", score); end
        keys = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        test_reset();
        test_hit();
        test_miss();
        test_rearm();
        test_back_to_back();
        test_reset_midwindow();
        test_saturation();
`ifdef NOTE_MATCH_JUDGE_PERFECT_EN
        test_perfect();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_match_judge.md
NOTE_MATCH_JUDGE -- requirements
Module: note_match_judge

Interface
REQ-001 Parameter WIDTH, default 4, number of key lanes compared per note.
REQ-002 Parameter WINDOW, default 8, judgement window length in clock cycles (legal range 2..255).
REQ-003 Parameter SCORE_W, default 16, width of the score accumulator.
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port note_valid  input  1  one-cycle strobe: a new expected note is presented on note_pattern.
REQ-007 Port note_pattern  input  WIDTH  expected key vector for the note; sampled only when note_valid=1.
REQ-008 Port keys  input  WIDTH  key vector, already synchronised and debounced upstream.
REQ-009 Port armed  output  1  high while a note is being judged.
REQ-010 Port hit  output  1  one-cycle pulse: the current note was matched inside the window.
REQ-011 Port miss  output  1  one-cycle pulse: the current note was not matched.
REQ-012 Port score  output  SCORE_W  accumulated score.
REQ-013 Port combo  output  8  count of consecutive hits.

Function
REQ-014 Match SHALL mean keys equals the latched pattern on every lane, bitwise (XNOR of each lane, AND-reduced); partial or extra keys are not a match.
REQ-015 FSM states: IDLE, ARMED. armed SHALL equal (state==ARMED).
REQ-016 IDLE + note_valid with a nonzero note_pattern -> latch pattern, load the window counter with WINDOW-1, go to ARMED.
REQ-017 note_valid with an all-zero note_pattern SHALL be ignored in every state.
REQ-018 In ARMED, a match on a cycle -> hit=1 on the following cycle, score+1, combo+1, go to IDLE.
REQ-019 In ARMED, no match with counter==0 -> miss=1 on the following cycle, combo cleared to 0, go to IDLE; otherwise the counter decrements.
REQ-020 The window SHALL therefore span exactly WINDOW consecutive compare cycles, starting the cycle after the note_valid strobe.
REQ-021 In ARMED, a nonzero note_valid without a match -> miss for the old note, the new pattern is latched, the counter is reloaded, and the block stays in ARMED.
REQ-022 In ARMED, a match and a nonzero note_valid on the same cycle -> hit for the old note (the hit takes precedence), the new pattern is latched, and the block stays in ARMED.
REQ-023 hit and miss SHALL never be asserted together.
REQ-024 score and combo SHALL saturate at all-ones and never wrap.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, latched pattern=0, hit=0, miss=0, armed=0, score=0, combo=0.
REQ-026 Reset asserted mid-window SHALL abandon the note with no hit or miss pulse; after release the block waits in IDLE for note_valid.

Configuration
REQ-027 Macro NOTE_MATCH_JUDGE_PERFECT_EN defined -> extra output port perfect (1 bit) pulses together with hit when the match lands in the first ceil(WINDOW/2) compare cycles, and that hit adds 2 to score instead of 1, still saturating.
REQ-028 Macro NOTE_MATCH_JUDGE_PERFECT_EN undefined -> no perfect port, and every hit adds 1.

Structure
REQ-029 Shared package judge_pkg SHALL hold the state encoding (IDLE=0, ARMED=1) and the default constants for WIDTH, WINDOW and SCORE_W.
REQ-030 The lane compare SHALL be a sub-module compare_nbit (parameter WIDTH; inputs A, B; output equal), instantiated once.

Verification (WIDTH=4, WINDOW=8)
REQ-031 note_valid with pattern 4'b0101, then keys=4'b0101 on the 3rd compare cycle -> hit pulse one cycle later, score=1, combo=1, armed falls.
REQ-032 note_valid with 4'b0011, keys=4'b0111 held for 8 cycles -> miss after the 8th compare cycle, score unchanged, combo=0.
REQ-033 Second note_valid with 4'b1000 arriving in ARMED while no match -> one miss, armed stays high, a later keys=4'b1000 -> hit.
REQ-034 Preload score to all-ones minus 1, then two hits -> score=all-ones; 256 consecutive hits -> combo=255.
REQ-035 rst_n pulsed low mid-window -> all outputs 0 immediately (asynchronous), no hit or miss pulse after release; note_valid with 4'b0000 -> armed stays 0.
REQ-036 With NOTE_MATCH_JUDGE_PERFECT_EN defined, a match on compare cycle 2 -> perfect=1 and score+2; a match on compare cycle 6 -> perfect=0 and score+1.
